// File: rtl/headbang_nod_sequencer_pkg.sv
// Shared types and default timing constants for the head-bang nod sequencer.
// The optional HEADBANG_NOD_RETRIGGER_EN macro is consumed by the top module.
package headbang_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    HOLD = 2'd2,
    UP   = 2'd3
  } nod_state_t;

  // 50 MHz clock: 20 ms frame, 1.5 ms rest, 2.0 ms head-down
  localparam int DEF_PERIOD_CYC   = 1_000_000;
  localparam int DEF_PW_REST      = 75_000;
  localparam int DEF_PW_DOWN      = 100_000;
  localparam int DEF_STEP         = 2_500;
  localparam int DEF_HOLD_PERIODS = 5;

  localparam int NOD_CNT_W = 8;

endpackage

// File: rtl/headbang_nod_sequencer_if.sv
// Trigger/status bundle between the PIO side (master) and the sequencer (slave).
// No build macros are used in this file.
interface headbang_nod_sequencer_if;
  import headbang_pkg::*;

  logic                 trigger;
  logic                 servo_pwm;
  logic                 busy;
  logic [NOD_CNT_W-1:0] nod_count;

  modport master (output trigger, input servo_pwm, input busy, input nod_count);
  modport slave  (input trigger, output servo_pwm, output busy, output nod_count);

endinterface

// File: rtl/headbang_nod_sequencer_servo_pwm_gen.sv
// Free-running servo frame counter with a registered pulse-width compare.
// No build macros are used in this file.
module servo_pwm_gen
  import headbang_pkg::*;
#(
  parameter int PERIOD_CYC = DEF_PERIOD_CYC,
  parameter int CNT_W      = $clog2(PERIOD_CYC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] i_pw,
  output logic             o_frame_end,
  output logic             o_pwm
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pwm;
  logic             w_frame_end;

  assign w_frame_end = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= w_frame_end ? '0 : r_cnt + CNT_W'(1);
      r_pwm <= (r_cnt < i_pw);
    end
  end

  assign o_frame_end = w_frame_end;
  assign o_pwm       = r_pwm;

endmodule

// File: rtl/headbang_nod_sequencer.sv
// Turns a rising edge on the PIO trigger into one servo nod: ramp down, hold, ramp back.
// Optional macro: HEADBANG_NOD_RETRIGGER_EN queues one nod requested mid-sequence.
module headbang_nod_sequencer
  import headbang_pkg::*;
#(
  parameter int PERIOD_CYC   = DEF_PERIOD_CYC,
  parameter int PW_REST      = DEF_PW_REST,
  parameter int PW_DOWN      = DEF_PW_DOWN,
  parameter int STEP         = DEF_STEP,
  parameter int HOLD_PERIODS = DEF_HOLD_PERIODS
) (
  input logic                     clk,
  input logic                     reset,
  headbang_nod_sequencer_if.slave bus
);

  localparam int CNT_W  = $clog2(PERIOD_CYC);
  localparam int ARW    = CNT_W + 1;
  localparam int HOLD_W = $clog2(HOLD_PERIODS + 1);
  // A step larger than the ramp span saturates identically, so clamping it keeps the sum in ARW bits
  localparam int STEP_C = (STEP > (PW_DOWN - PW_REST)) ? (PW_DOWN - PW_REST) : STEP;

  localparam logic [ARW-1:0]    A_REST    = ARW'(PW_REST);
  localparam logic [ARW-1:0]    A_DOWN    = ARW'(PW_DOWN);
  localparam logic [ARW-1:0]    A_STEP    = ARW'(STEP_C);
  localparam logic [ARW-1:0]    A_DEC_MIN = ARW'(PW_REST + STEP_C);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

  generate
    if (!((PW_REST < PW_DOWN) && (PW_DOWN < PERIOD_CYC) && (STEP > 0) && (HOLD_PERIODS >= 1)))
    begin : g_bad_params
      $error("headbang_nod_sequencer: illegal timing parameters");
    end
  endgenerate

  nod_state_t            r_state, w_state_next;
  logic [CNT_W-1:0]      r_pw, w_pw_next;
  logic [HOLD_W-1:0]     r_hold, w_hold_next;
  logic [NOD_CNT_W-1:0]  r_count, w_count_next;
  logic                  r_pending, w_pending_next;
  logic                  r_trig_q;

  logic                  w_edge;
  logic                  w_frame_end;
  logic                  w_servo_pwm;
  logic [ARW-1:0]        w_sum;
  logic [ARW-1:0]        w_pw_inc;
  logic [ARW-1:0]        w_pw_dec;

  servo_pwm_gen #(
    .PERIOD_CYC (PERIOD_CYC),
    .CNT_W      (CNT_W)
  ) u_pwm (
    .clk         (clk),
    .reset       (reset),
    .i_pw        (r_pw),
    .o_frame_end (w_frame_end),
    .o_pwm       (w_servo_pwm)
  );

  // trig_q resets high so a level already asserted at reset release is not an edge
  assign w_edge   = bus.trigger & ~r_trig_q;
  assign w_sum    = {1'b0, r_pw} + A_STEP;
  assign w_pw_inc = (w_sum > A_DOWN) ? A_DOWN : w_sum;
  assign w_pw_dec = ({1'b0, r_pw} < A_DEC_MIN) ? A_REST : ({1'b0, r_pw} - A_STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pw      <= CNT_W'(PW_REST);
      r_hold    <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
      r_trig_q  <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_pw      <= w_pw_next;
      r_hold    <= w_hold_next;
      r_count   <= w_count_next;
      r_pending <= w_pending_next;
      r_trig_q  <= bus.trigger;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pw_next      = r_pw;
    w_hold_next    = r_hold;
    w_count_next   = r_count;
    w_pending_next = r_pending;

`ifdef HEADBANG_NOD_RETRIGGER_EN
    if (w_edge) w_pending_next = 1'b1;
`else
    if (w_edge && (r_state == IDLE)) w_pending_next = 1'b1;
`endif

    if (w_frame_end) begin
      case (r_state)
        IDLE: begin
          // an edge landing on the frame boundary starts at once and never lingers in pending
          if (r_pending || w_edge) begin
            w_state_next   = DOWN;
            w_pending_next = 1'b0;
          end
        end
        DOWN: begin
          w_pw_next = w_pw_inc[CNT_W-1:0];
          if (w_pw_inc == A_DOWN) begin
            w_state_next = HOLD;
            w_hold_next  = '0;
          end
        end
        HOLD: begin
          w_hold_next = r_hold + HOLD_W'(1);
          if (r_hold == HOLD_LAST) w_state_next = UP;
        end
        UP: begin
          w_pw_next = w_pw_dec[CNT_W-1:0];
          if (w_pw_dec == A_REST) begin
            w_state_next = IDLE;
            w_count_next = r_count + NOD_CNT_W'(1);
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign bus.servo_pwm = w_servo_pwm;
  assign bus.busy      = (r_state != IDLE) | r_pending;
  assign bus.nod_count = r_count;

endmodule

// File: tb/tb_headbang_nod_sequencer.sv
// Self-checking bench: frame-table vectors, hand sequences, random triggers vs a frame-plan model.
// Works with or without HEADBANG_NOD_RETRIGGER_EN defined.
module tb_headbang_nod_sequencer;
  import headbang_pkg::*;

  localparam int P     = 100;
  localparam int REST  = 10;
  localparam int DOWN_W = 20;
  localparam int STP   = 5;
  localparam int HOLDP = 2;
`ifdef HEADBANG_NOD_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  typedef struct {
    int trig_at;
    int exp_w;
    int exp_busy;
    int exp_cnt;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  headbang_nod_sequencer_if hb();
  headbang_nod_sequencer_if hb2();

  headbang_nod_sequencer #(
    .PERIOD_CYC(P), .PW_REST(REST), .PW_DOWN(DOWN_W), .STEP(STP), .HOLD_PERIODS(HOLDP)
  ) dut (
    .clk(clk), .reset(reset), .bus(hb.slave)
  );

  // small-period instance so 256 nods fit in a short run
  headbang_nod_sequencer #(
    .PERIOD_CYC(8), .PW_REST(2), .PW_DOWN(4), .STEP(2), .HOLD_PERIODS(1)
  ) dut_wrap (
    .clk(clk), .reset(reset), .bus(hb2.slave)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Frame-plan reference model: a nod is a queue of per-frame widths built from the ramp rules
  int m_cnt   = 0;
  int m_w     = REST;
  int m_count = 0;
  bit m_run   = 1'b0;
  bit m_pend  = 1'b0;
  bit m_prev  = 1'b1;
  bit m_pwm   = 1'b0;
  bit m_edge  = 1'b0;
  int m_q[$];

  task automatic build_plan();
    int w;
    w = REST;
    while (w < DOWN_W) begin
      m_q.push_back(w);
      w = (w + STP > DOWN_W) ? DOWN_W : w + STP;
    end
    repeat (HOLDP) m_q.push_back(DOWN_W);
    while (w > REST) begin
      m_q.push_back(w);
      w = (w - STP < REST) ? REST : w - STP;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_cnt = 0; m_w = REST; m_count = 0; m_run = 1'b0; m_pend = 1'b0;
      m_prev = 1'b1; m_pwm = 1'b0; m_q.delete();
    end else begin
      m_edge = hb.trigger && !m_prev;
      m_prev = hb.trigger;
      m_pwm  = (m_cnt < m_w);
      if (m_edge && (!m_run || RETRIG)) m_pend = 1'b1;
      if (m_cnt == P - 1) begin
        if (m_run) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_run = 1'b0;
            m_count = (m_count + 1) % 256;
          end
        end else if (m_pend) begin
          build_plan();
          m_run  = 1'b1;
          m_pend = 1'b0;
        end
        m_w = m_run ? m_q[0] : REST;
      end
      m_cnt = (m_cnt + 1) % P;
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      checks++;
      if (hb.servo_pwm !== m_pwm || hb.busy !== (m_run | m_pend) ||
          hb.nod_count !== NOD_CNT_W'(m_count)) begin
        errors++;
        $display("FAIL model_cycle t=%0t pwm/busy/count got %b/%b/%0d want %b/%b/%0d",
                 $time, hb.servo_pwm, hb.busy, hb.nod_count, m_pwm, m_run | m_pend, m_count);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, want);
    end
  endtask

  task automatic align();
    int n;
    n = 0;
    while (m_cnt != 1 && n < 3 * P) begin
      @(negedge clk);
      n++;
    end
    check("align_timeout", 32'(n < 3 * P), 32'd1);
  endtask

  // one frame starting at the negedge whose next posedge has cnt==1; pulses trigger at cnt==trig_at
  task automatic run_frame(input int trig_at, input bit lvl, output int hi);
    hi = 0;
    for (int i = 0; i < P; i++) begin
      hb.trigger = lvl ^ (((i + 1) % P) == trig_at);
      hi += int'(hb.servo_pwm);
      @(negedge clk);
    end
    hb.trigger = lvl;
  endtask

  task automatic retrig_test(input bit three);
    int hi;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    align();
    for (int f = 0; f < 16; f++)
      run_frame((f == 0 || f == 3 || (three && f == 5)) ? 40 : -1, 1'b0, hi);
    check(three ? "retrig3_count" : "retrig2_count", 32'(hb.nod_count), RETRIG ? 32'd2 : 32'd1);
    check(three ? "retrig3_busy" : "retrig2_busy", 32'(hb.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog t=%0t got timeout want completion", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    vec_t vecs[11];
    int hi;
    int k;
    vecs[0]  = '{-1, 10, 0, 0};
    vecs[1]  = '{-1, 10, 0, 0};
    vecs[2]  = '{-1, 10, 0, 0};
    vecs[3]  = '{40, 10, 1, 0};
    vecs[4]  = '{-1, 10, 1, 0};
    vecs[5]  = '{-1, 15, 1, 0};
    vecs[6]  = '{-1, 20, 1, 0};
    vecs[7]  = '{-1, 20, 1, 0};
    vecs[8]  = '{-1, 20, 1, 0};
    vecs[9]  = '{-1, 15, 0, 1};
    vecs[10] = '{-1, 10, 0, 1};

    hb.trigger  = 1'b0;
    hb2.trigger = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pwm", 32'(hb.servo_pwm), 32'd0);
    check("reset_busy", 32'(hb.busy), 32'd0);
    check("reset_count", 32'(hb.nod_count), 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    align();
    for (int v = 0; v < 11; v++) begin
      run_frame(vecs[v].trig_at, 1'b0, hi);
      check($sformatf("vec%0d_width", v), 32'(hi), 32'(vecs[v].exp_w));
      check($sformatf("vec%0d_busy", v), 32'(hb.busy), 32'(vecs[v].exp_busy));
      check($sformatf("vec%0d_count", v), 32'(hb.nod_count), 32'(vecs[v].exp_cnt));
    end

    // trigger already high at reset release must not start a nod
    hb.trigger = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    align();
    for (int f = 0; f < 3; f++) begin
      run_frame(-1, 1'b1, hi);
      check("held_width", 32'(hi), 32'd10);
      check("held_busy", 32'(hb.busy), 32'd0);
    end
    hb.trigger = 1'b0;

    retrig_test(1'b0);
    retrig_test(1'b1);

    // reset mid-HOLD with a nonzero count from the previous test
    align();
    for (int f = 0; f < 3; f++) run_frame((f == 0) ? 40 : -1, 1'b0, hi);
    repeat (50) @(negedge clk);
    check("hold_busy_before", 32'(hb.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("hold_rst_busy", 32'(hb.busy), 32'd0);
    check("hold_rst_count", 32'(hb.nod_count), 32'd0);
    check("hold_rst_pwm", 32'(hb.servo_pwm), 32'd0);
    reset = 1'b0;
    align();
    run_frame(-1, 1'b0, hi);
    check("after_rst_width", 32'(hi), 32'd10);
    check("after_rst_busy", 32'(hb.busy), 32'd0);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) hb.trigger = ~hb.trigger;
      reset = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    hb.trigger = 1'b0;

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int n = 1; n <= 256; n++) begin
      hb2.trigger = 1'b1;
      @(negedge clk);
      hb2.trigger = 1'b0;
      check("wrap_busy_rise", 32'(hb2.busy), 32'd1);
      k = 0;
      while (hb2.busy && k < 200) begin
        @(negedge clk);
        k++;
      end
      check("wrap_busy_fall", 32'(k < 200), 32'd1);
      if (n == 255) check("wrap_count_255", 32'(hb2.nod_count), 32'd255);
      if (n == 256) check("wrap_count_0", 32'(hb2.nod_count), 32'd0);
    end
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      hi += int'(hb2.servo_pwm);
      @(negedge clk);
    end
    check("wrap_idle_width", 32'(hi), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/headbang_nod_sequencer.md
# headbang_nod_sequencer

Converts the single-bit nod trigger written by software through the audio system's 1-bit output PIO into one complete head-bang motion on a hobby servo. A rising edge on the trigger starts a timed sequence: ramp down, hold, ramp back to rest. The block generates the 50 Hz servo PWM and changes pulse width only on frame boundaries. It sits directly downstream of the PIO `out_port`, in the same clock domain.

## Interface
- `PERIOD_CYC`, default 1_000_000: clocks per PWM frame (20 ms at 50 MHz).
- `PW_REST`, default 75_000: rest pulse width in clocks (1.5 ms).
- `PW_DOWN`, default 100_000: head-down pulse width in clocks (2.0 ms).
- `STEP`, default 2_500: pulse-width change per frame while ramping.
- `HOLD_PERIODS`, default 5: frames held at `PW_DOWN`.
- `clk`  in  1  system clock.
- `reset`  in  1  reset. Asynchronous and active-high.
- `trigger`  in  1  nod request, driven by PIO `out_port`.
- `servo_pwm`  out  1  registered servo pulse.
- `busy`  out  1  high while a nod is pending or running.
- `nod_count`  out  8  completed nods, wrapping counter.

## Operation
- Legal parameters: `PW_REST < PW_DOWN < PERIOD_CYC`, `STEP > 0`, `HOLD_PERIODS >= 1`. Elaboration fails otherwise.
- Frame counter `cnt` width is `$clog2(PERIOD_CYC)`.
  - Counts 0..`PERIOD_CYC-1` and wraps, free-running from reset.
  - `frame_end` is asserted when `cnt == PERIOD_CYC-1`.
- `servo_pwm <= (cnt < pw)`.
- `pw` changes only on `frame_end`, so a frame is never truncated or stretched.
- Edge detect: `trig_q <= trigger`. `edge = trigger & ~trig_q`.
  - `trig_q` resets to 1, so a level that is already high at reset release does not start a nod.
- `pending` is set by `edge` while in IDLE. It is cleared when DOWN is entered.
- FSM transitions are evaluated only on `frame_end`:
  - IDLE: if `pending | edge`, go to DOWN.
  - DOWN: `pw <= min(pw+STEP, PW_DOWN)`. When the result equals `PW_DOWN`, go to HOLD and set `hold_cnt=0`.
  - HOLD: `hold_cnt++`. When `hold_cnt == HOLD_PERIODS-1`, go to UP.
  - UP: `pw <= max(pw-STEP, PW_REST)`. When the result equals `PW_REST`, go to IDLE and increment `nod_count` (255 wraps to 0).
- Saturating arithmetic is computed one bit wider than `cnt`, so no overflow or underflow is possible.
- `busy = (state != IDLE) | pending`, combinational from registers.
- Edges arriving while not in IDLE are ignored; see Configuration.
- `edge` and `frame_end` in the same cycle while in IDLE: the nod starts on that frame boundary and `pending` stays 0.
- Reset at any time, including mid-sequence, forces every register to its reset value at once.

## Timing
- Reset values: `servo_pwm=0`, `busy=0`, `nod_count=0`, `pw=PW_REST`, `cnt=0`, state IDLE, `pending=0`, `trig_q=1`.
- `servo_pwm` lags the `cnt` compare by one clock.
- First high cycle is the 2nd clock after reset release.
- Start latency: from the edge to the first changed frame is up to one frame, i.e. until the next `frame_end`.
- Sequence length is `2*ceil((PW_DOWN-PW_REST)/STEP) + HOLD_PERIODS` frames.
  - Defaults: 10+5+10 = 25 frames = 500 ms.
- `busy` rises one clock after the edge (`pending` registered). It falls in the cycle after the `frame_end` that enters IDLE.

## Configuration
- `HEADBANG_NOD_RETRIGGER_EN`
  - Defined: an edge seen while not in IDLE sets `pending`. That one queued nod starts on the first `frame_end` after returning to IDLE. Further edges are discarded (depth 1).
  - Undefined: `pending` can only be set in IDLE, and edges during a sequence are lost.

## Structure
- Package `headbang_pkg` holds:
  - the FSM state enum (IDLE, DOWN, HOLD, UP);
  - default timing constants;
  - the `nod_count` width of 8.
- Sub-module `servo_pwm_gen` contains the frame counter, `frame_end`, and the registered compare. It takes `pw` as input.
- The sequencer top holds the edge detect, `pending`, FSM, hold counter and `nod_count`.

## Test plan
Bench parameters: `PERIOD_CYC=100`, `PW_REST=10`, `PW_DOWN=20`, `STEP=5`, `HOLD_PERIODS=2`.
- Reset, then idle for 3 frames: `servo_pwm` high for 10 clocks per 100, `busy=0`, `nod_count=0`.
- Pulse `trigger` at `cnt=40`: widths go 10, 15, 20, 20, 20, 15, 10. `busy` is high throughout; `nod_count=1` after the 10-width frame resumes.
- `trigger` held high through reset release: no nod, `busy` stays 0.
- Second edge during HOLD, macro undefined: exactly one nod, `nod_count=1`.
- Same stimulus with the macro defined: two back-to-back nods, `nod_count=2`. Three edges give the same result.
- Assert `reset` while `pw=20` in HOLD: next frame width is 10, `nod_count=0`, `busy=0`.
- 256 nods: `nod_count` wraps to 0.
